// File: rtl/pipe_stage_skid.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_skid
// Description : Elastic pipeline register stage with a two-entry skid buffer.
//               Carries a WIDTH-bit payload under a valid/ready handshake.
//               in_ready is taken straight from a flop, so a stall travels
//               upstream one stage per cycle with no combinational ready
//               chain. A synchronous flush turns the stage into a bubble.
//
// Ports       : clock        rising-edge clock
//               reset        asynchronous active-high reset
//               in_valid     upstream presents a payload
//               in_ready     stage can accept (registered)
//               in_data      upstream payload [WIDTH]
//               flush        synchronous kill of all held payloads
//               out_valid    main register holds a valid payload
//               out_ready    downstream accepts this cycle
//               out_data     main payload, NOP_VALUE when out_valid=0
//               count        occupancy 0..2
//               stall_cycles cycles with out_valid=1 & out_ready=0
//
// Options     : PIPE_STAGE_STATS_EN - when defined, stall_cycles is a
//               saturating 32-bit counter cleared only by reset; when
//               undefined it is tied to zero and no counter is built.
//
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_skid #(
  parameter int               WIDTH     = 128,
  parameter logic [WIDTH-1:0] NOP_VALUE = {WIDTH{1'b0}}
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       count,
  output logic [31:0]      stall_cycles
);

  // Encoding is {skid_v, main_v}; 2'b10 is unreachable.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b11
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] main_data_q, main_data_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic             main_v, skid_v;
  logic             accept, drain;

  assign main_v    = state_q[0];
  assign skid_v    = state_q[1];

  assign in_ready  = ~skid_v;
  assign out_valid = main_v;
  // Stale data registers are hidden behind the bubble encoding.
  assign out_data  = main_v ? main_data_q : NOP_VALUE;
  assign count     = {1'b0, main_v} + {1'b0, skid_v};

  assign accept    = in_valid & in_ready;
  assign drain     = main_v & out_ready;

  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    skid_data_d = skid_data_q;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          state_d     = ST_ONE;
          main_data_d = in_data;
        end
      end
      ST_ONE: begin
        if (accept && drain) begin
          main_data_d = in_data;
        end else if (accept) begin
          // Downstream stalled: park the newer payload behind main.
          state_d     = ST_FULL;
          skid_data_d = in_data;
        end else if (drain) begin
          state_d     = ST_EMPTY;
        end
      end
      ST_FULL: begin
        // in_ready is low here, so only a drain can move the state.
        if (drain) begin
          state_d     = ST_ONE;
          main_data_d = skid_data_q;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase
    // Flush wins over everything; a same-cycle drain has already been
    // sampled downstream, and a same-cycle accept is simply dropped.
    if (flush) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_EMPTY;
      main_data_q <= '0;
      skid_data_q <= '0;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      skid_data_q <= skid_data_d;
    end
  end

`ifdef PIPE_STAGE_STATS_EN
  logic [31:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (main_v && !out_ready && (stall_q != 32'hFFFF_FFFF)) begin
      stall_d = stall_q + 32'd1;
    end
  end

  // Flush deliberately does not clear the statistic.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_q <= 32'h0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = 32'h0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_skid.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_stage_skid
// Description : Self-checking bench for pipe_stage_skid (WIDTH=128,
//               NOP_VALUE=0xDEAD). A negedge monitor keeps a FIFO
//               scoreboard of accepted payloads and checks each drained
//               payload, the bubble encoding and the stall statistic.
//               Scenario tasks check occupancy and ready inline.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_skid;

  localparam int           WIDTH = 128;
  localparam logic [127:0] NOP   = 128'hDEAD;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic             flush = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       count;
  logic [31:0]      stall_cycles;

  int tests = 0;
  int fails = 0;

  logic [WIDTH-1:0] sb_q[$];
  logic [31:0]      stall_exp = 32'h0;

  pipe_stage_skid #(
    .WIDTH    (WIDTH),
    .NOP_VALUE(NOP)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .count       (count),
    .stall_cycles(stall_cycles)
  );

  always #5 clock = ~clock;

  // Scoreboard monitor: inputs change at posedge+1, so the negedge sees the
  // exact values the next rising edge will act on.
  always @(negedge clock) begin
    logic [31:0]      stall_ref;
    logic [WIDTH-1:0] exp_d;
    if (reset) begin
      sb_q.delete();
      stall_exp = 32'h0;
    end else begin
`ifdef PIPE_STAGE_STATS_EN
      stall_ref = stall_exp;
`else
      stall_ref = 32'h0;
`endif
      tests++;
      if (stall_cycles !== stall_ref) begin
        fails++;
        $display("FAIL stall_cycles: got %0d expected %0d at %0t", stall_cycles, stall_ref, $time);
      end
      if (!out_valid) begin
        tests++;
        if (out_data !== NOP) begin
          fails++;
          $display("FAIL bubble_data: got %h expected %h at %0t", out_data, NOP, $time);
        end
      end
      if ((sb_q.size() > 0) && !out_ready && (stall_exp != 32'hFFFF_FFFF))
        stall_exp = stall_exp + 32'd1;
      if (out_valid && out_ready) begin
        tests++;
        if (sb_q.size() == 0) begin
          fails++;
          $display("FAIL drain_extra: got %h expected no payload at %0t", out_data, $time);
        end else begin
          exp_d = sb_q.pop_front();
          if (out_data !== exp_d) begin
            fails++;
            $display("FAIL drain_data: got %h expected %h at %0t", out_data, exp_d, $time);
          end
        end
      end
      if (in_valid && in_ready) sb_q.push_back(in_data);
      if (flush) sb_q.delete();
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== NOP ||
        count !== 2'd0 || stall_cycles !== 32'h0) begin
      fails++;
      $display("FAIL reset_values: got rdy=%b v=%b d=%h cnt=%0d st=%0d expected 1 0 %h 0 0",
               in_ready, out_valid, out_data, count, stall_cycles, NOP);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_streaming();
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1;
      in_data  = WIDTH'(i);
      tick();
      tests++;
      if (out_data !== WIDTH'(i) || count !== 2'd1 || in_ready !== 1'b1) begin
        fails++;
        $display("FAIL stream_%0d: got d=%h cnt=%0d rdy=%b expected d=%0d cnt=1 rdy=1",
                 i, out_data, count, in_ready, i);
      end
    end
    in_valid = 1'b0;
    tick();
    tick();
    tests++;
    if (count !== 2'd0 || sb_q.size() != 0) begin
      fails++;
      $display("FAIL stream_drain: got cnt=%0d pending=%0d expected 0 0", count, sb_q.size());
    end
  endtask

  task automatic test_backpressure();
    int n;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 128'hA;
    tick();
    tests++;
    if (count !== 2'd1 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL bp_one: got cnt=%0d rdy=%b expected 1 1", count, in_ready);
    end
    in_data = 128'hB;
    tick();
    tests++;
    if (count !== 2'd2 || in_ready !== 1'b0) begin
      fails++;
      $display("FAIL bp_full: got cnt=%0d rdy=%b expected 2 0", count, in_ready);
    end
    in_data = 128'hC;
    tick();
    tick();
    tests++;
    if (count !== 2'd2 || in_ready !== 1'b0 || out_data !== 128'hA) begin
      fails++;
      $display("FAIL bp_hold: got cnt=%0d rdy=%b d=%h expected 2 0 a", count, in_ready, out_data);
    end
    out_ready = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    tests++;
    if (n >= 20) begin
      fails++;
      $display("FAIL bp_timeout: got in_ready=%b after %0d cycles expected 1", in_ready, n);
    end
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    tests++;
    if (count !== 2'd0 || sb_q.size() != 0) begin
      fails++;
      $display("FAIL bp_drain: got cnt=%0d pending=%0d expected 0 0", count, sb_q.size());
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 128'h11;
    tick();
    in_data = 128'h22;
    tick();
    tests++;
    if (count !== 2'd2) begin
      fails++;
      $display("FAIL flush_fill: got cnt=%0d expected 2", count);
    end
    flush   = 1'b1;
    in_data = 128'h33;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    tests++;
    if (count !== 2'd0 || out_valid !== 1'b0 || out_data !== NOP || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL flush_full: got cnt=%0d v=%b d=%h rdy=%b expected 0 0 %h 1",
               count, out_valid, out_data, in_ready, NOP);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++;
      if (out_valid !== 1'b0) begin
        fails++;
        $display("FAIL flush_ghost: got out_valid=%b d=%h expected 0", out_valid, out_data);
      end
    end
    // Flush while draining and accepting: drain completes, accept dropped.
    in_valid = 1'b1;
    in_data  = 128'h44;
    tick();
    in_data = 128'h55;
    flush   = 1'b1;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    tests++;
    if (count !== 2'd0 || out_valid !== 1'b0 || sb_q.size() != 0) begin
      fails++;
      $display("FAIL flush_one: got cnt=%0d v=%b pending=%0d expected 0 0 0",
               count, out_valid, sb_q.size());
    end
    tick();
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 128'h66;
    tick();
    in_data = 128'h77;
    tick();
    in_valid = 1'b0;
    tests++;
    if (count !== 2'd2) begin
      fails++;
      $display("FAIL areset_fill: got cnt=%0d expected 2", count);
    end
    #2;
    reset = 1'b1;
    #1;
    tests++;
    if (out_valid !== 1'b0 || out_data !== NOP || count !== 2'd0 ||
        in_ready !== 1'b1 || stall_cycles !== 32'h0) begin
      fails++;
      $display("FAIL areset_now: got v=%b d=%h cnt=%0d rdy=%b st=%0d expected 0 %h 0 1 0",
               out_valid, out_data, count, in_ready, stall_cycles, NOP);
    end
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_stats();
    logic [31:0] exp5;
`ifdef PIPE_STAGE_STATS_EN
    exp5 = 32'd5;
`else
    exp5 = 32'd0;
`endif
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 128'h88;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    tests++;
    if (stall_cycles !== exp5) begin
      fails++;
      $display("FAIL stats_count: got %0d expected %0d", stall_cycles, exp5);
    end
    out_ready = 1'b1;
    flush     = 1'b1;
    tick();
    flush     = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    tests++;
    if (stall_cycles !== exp5 || count !== 2'd0) begin
      fails++;
      $display("FAIL stats_flush: got st=%0d cnt=%0d expected %0d 0", stall_cycles, count, exp5);
    end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_stats();
    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
